// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with PC and IF/ID register; define IF_PERF_CNT_EN for fetch/stall counters
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_freeze,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_addr,
  input  logic        i_flush,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  output logic        o_if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_target;
  logic        w_kill;
  logic        w_load;

  // Sequential PC arithmetic wraps naturally at 2^32.
  assign w_pc_plus4      = r_pc + 32'd4;
  // Targets are forced word-aligned; the low address bits are discarded.
  assign w_branch_target = i_branch_addr & ~32'd3;
  // A taken branch squashes whatever is being fetched this cycle, same as flush.
  assign w_kill          = i_flush | i_branch_taken;
  assign w_load          = ~w_kill & ~i_freeze;

  // Memory is combinational, so the PC itself addresses it with no extra latency.
  assign o_imem_addr = r_pc;

  // Program counter: reset, then branch redirect (beats freeze), then hold, then advance.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_branch_taken) begin
      r_pc <= w_branch_target;
    end else if (!i_freeze) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID register: reset, then squash (beats freeze), then hold, then capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_if_instr <= NOP_INSTR;
      o_if_pc    <= 32'd0;
      o_if_valid <= 1'b0;
    end else if (w_kill) begin
      o_if_instr <= NOP_INSTR;
      o_if_pc    <= 32'd0;
      o_if_valid <= 1'b0;
    end else if (!i_freeze) begin
      o_if_instr <= i_imem_instr;
      o_if_pc    <= w_pc_plus4;
      o_if_valid <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Counters: fetches are edges that load a live instruction; stalls are freezes not overridden by a branch.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_fetch_cnt <= 32'd0;
      o_stall_cnt <= 32'd0;
    end else begin
      if (w_load) begin
        o_fetch_cnt <= o_fetch_cnt + 32'd1;
      end
      if (i_freeze && !i_branch_taken) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
